// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle logic/arithmetic ops and iterative
// multi-cycle MUL / DIVU / REMU (one bit per cycle). One operation in flight.
//
// Build option: define ALU_SEQ_DIV_EN to include the divider. Without it,
// opcodes 11/12 report err=1 with out=0 in a single cycle. MUL is always present.
//
// Ports
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   in_valid   request valid          in_ready   block can accept a request
//   op         opcode (4 bits)        in_r/in_rw operands (WIDTH bits)
//   out_valid  result valid           out_ready  consumer accepts result
//   out        result                 is_zero    out == 0
//   carry      ADD carry-out / SUB borrow, 0 otherwise
//   err        illegal opcode or divide by zero
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no result held, ready for a request
// S_BUSY | iterating a multi-cycle op, cnt counts down to 0
// S_DONE | result held on out/flags until consumed
module alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] in_r,
   input  logic [WIDTH-1:0] in_rw,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             is_zero,
   output logic             carry,
   output logic             err
);

   localparam int SHW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
   typedef enum logic [1:0] {K_MUL, K_DIVU, K_REMU} kind_t;

   state_t           state, state_nxt;
   kind_t            kind;
   logic [SHW-1:0]   cnt;
   logic [WIDTH-1:0] acc, opa, opb;
   logic [WIDTH-1:0] acc_nxt, opa_nxt, opb_nxt, iter_res;

   logic             accept;
   logic [WIDTH:0]   sum_w;
   logic             shamt_ovf;
   logic [WIDTH-1:0] sc_res;
   logic             sc_carry, sc_err, is_multi;

   assign accept    = in_valid & in_ready;
   assign sum_w     = {1'b0, in_r} + {1'b0, in_rw};
   assign shamt_ovf = |in_rw[WIDTH-1:SHW];

   // Single-cycle result, and whether the request needs the iterative engine.
   always_comb begin
      sc_res   = '0;
      sc_carry = 1'b0;
      sc_err   = 1'b0;
      is_multi = 1'b0;
      case (op)
         4'd0: begin
            sc_res   = sum_w[WIDTH-1:0];
            sc_carry = sum_w[WIDTH];
         end
         4'd1: begin
            sc_res   = in_r - in_rw;
            sc_carry = (in_r < in_rw);
         end
         4'd2: sc_res = shamt_ovf ? '0 : (in_r << in_rw[SHW-1:0]);
         4'd3: sc_res = shamt_ovf ? '0 : (in_r >> in_rw[SHW-1:0]);
         4'd4: sc_res = in_r;
         4'd5: sc_res = in_rw;
         4'd6: sc_res = in_r & in_rw;
         4'd7: sc_res = in_r | in_rw;
         4'd8: sc_res = in_r ^ in_rw;
         4'd9: sc_res = (in_r << 8) | in_rw;
         4'd10: is_multi = 1'b1;
`ifdef ALU_SEQ_DIV_EN
         // Divide by zero is resolved immediately instead of running the engine.
         4'd11: begin
            if (in_rw == '0) begin
               sc_res = '1;
               sc_err = 1'b1;
            end else begin
               is_multi = 1'b1;
            end
         end
         4'd12: begin
            if (in_rw == '0) begin
               sc_res = in_r;
               sc_err = 1'b1;
            end else begin
               is_multi = 1'b1;
            end
         end
`endif
         default: sc_err = 1'b1;
      endcase
   end

   // One engine iteration. MUL: LSB-first shift-add (opa = shifted multiplicand,
   // opb = remaining multiplier). DIV: restoring, opa shifts dividend bits out
   // at the top and quotient bits in at the bottom, acc holds the remainder.
`ifdef ALU_SEQ_DIV_EN
   logic [WIDTH:0] rem_tmp;
   logic           ge;
`endif
   always_comb begin
      acc_nxt  = acc + (opb[0] ? opa : '0);
      opa_nxt  = opa << 1;
      opb_nxt  = opb >> 1;
      iter_res = acc_nxt;
`ifdef ALU_SEQ_DIV_EN
      rem_tmp = {acc, opa[WIDTH-1]};
      ge      = (rem_tmp >= {1'b0, opb});
      if (kind != K_MUL) begin
         // remainder stays below the divisor, so the low WIDTH bits suffice
         acc_nxt  = ge ? (rem_tmp[WIDTH-1:0] - opb) : rem_tmp[WIDTH-1:0];
         opa_nxt  = {opa[WIDTH-2:0], ge};
         opb_nxt  = opb;
         iter_res = (kind == K_DIVU) ? opa_nxt : acc_nxt;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) state_nxt = is_multi ? S_BUSY : S_DONE;
         end
         S_BUSY: begin
            if (cnt == '0) state_nxt = S_DONE;
         end
         S_DONE: begin
            if (accept)         state_nxt = is_multi ? S_BUSY : S_DONE;
            else if (out_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // in_ready is qualified by reset_n so it reads 0 while reset is held.
   always_comb begin
      out_valid = (state == S_DONE);
      in_ready  = reset_n & ((state == S_IDLE) | ((state == S_DONE) & out_ready));
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out     <= '0;
         is_zero <= 1'b1;
         carry   <= 1'b0;
         err     <= 1'b0;
         cnt     <= '0;
         kind    <= K_MUL;
         acc     <= '0;
         opa     <= '0;
         opb     <= '0;
      end else if (accept) begin
         if (is_multi) begin
            cnt  <= SHW'(WIDTH - 1);
            kind <= (op == 4'd10) ? K_MUL : ((op == 4'd11) ? K_DIVU : K_REMU);
            acc  <= '0;
            opa  <= in_r;
            opb  <= in_rw;
         end else begin
            out     <= sc_res;
            is_zero <= (sc_res == '0);
            carry   <= sc_carry;
            err     <= sc_err;
         end
      end else if (state == S_BUSY) begin
         acc <= acc_nxt;
         opa <= opa_nxt;
         opb <= opb_nxt;
         cnt <= cnt - 1'b1;
         if (cnt == '0) begin
            out     <= iter_res;
            is_zero <= (iter_res == '0);
            carry   <= 1'b0;
            err     <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

   localparam int W = 32;

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [3:0]     op = 4'd0;
   logic [W-1:0]   in_r = '0;
   logic [W-1:0]   in_rw = '0;
   logic           out_valid;
   logic           out_ready = 1'b1;
   logic [W-1:0]   out;
   logic           is_zero, carry, err;

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .in_r      (in_r),
      .in_rw     (in_rw),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .is_zero   (is_zero),
      .carry     (carry),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] out;
      logic         z;
      logic         c;
      logic         e;
      int           lat;
      int           vis;
   } exp_t;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   acc_count = 0;
   int   ready_mode = 0;
   logic rst_edge = 1'b0;
   exp_t q[$];
   exp_t mon_e;
   logic mon_ev, mon_er;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: what each opcode must produce, from plain unsigned arithmetic.
   function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t r;
      logic [W:0]     s;
      logic [2*W-1:0] p;
      r.out = '0; r.c = 1'b0; r.e = 1'b0; r.lat = 1; r.vis = 0;
      case (o)
         4'd0: begin s = {1'b0, a} + {1'b0, b}; r.out = s[W-1:0]; r.c = s[W]; end
         4'd1: begin r.out = a - b; r.c = (a < b); end
         4'd2: r.out = (b >= W) ? '0 : (a << b);
         4'd3: r.out = (b >= W) ? '0 : (a >> b);
         4'd4: r.out = a;
         4'd5: r.out = b;
         4'd6: r.out = a & b;
         4'd7: r.out = a | b;
         4'd8: r.out = a ^ b;
         4'd9: r.out = (a << 8) | b;
         4'd10: begin p = (2*W)'(a) * (2*W)'(b); r.out = p[W-1:0]; r.lat = W + 1; end
`ifdef ALU_SEQ_DIV_EN
         4'd11: begin
            if (b == 0) begin r.out = '1; r.e = 1'b1; end
            else begin r.out = a / b; r.lat = W + 1; end
         end
         4'd12: begin
            if (b == 0) begin r.out = a; r.e = 1'b1; end
            else begin r.out = a % b; r.lat = W + 1; end
         end
`endif
         default: r.e = 1'b1;
      endcase
      r.z = (r.out == '0);
      return r;
   endfunction

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_edge <= ~reset_n;
   end

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'b0;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Compare process: checks every cycle, then predicts the coming edge.
   always @(negedge clk) begin
      if (cyc > 0) begin
         mon_ev = (q.size() != 0) && (cyc >= q[0].vis);
         mon_er = reset_n && ((q.size() == 0) || (mon_ev && out_ready));
         chk("in_ready", in_ready, mon_er);
         chk("out_valid", out_valid, mon_ev);
         if (mon_ev) begin
            chk("out", out, q[0].out);
            chk("is_zero", is_zero, q[0].z);
            chk("carry", carry, q[0].c);
            chk("err", err, q[0].e);
         end
         if (rst_edge) begin
            chk("rst_out", out, 0);
            chk("rst_is_zero", is_zero, 1);
            chk("rst_carry", carry, 0);
            chk("rst_err", err, 0);
         end
         if (!reset_n) begin
            q.delete();
         end else begin
            if (mon_ev && out_ready) void'(q.pop_front());
            if (in_valid && mon_er) begin
               mon_e = model(op, in_r, in_rw);
               mon_e.vis = cyc + mon_e.lat;
               q.push_back(mon_e);
               acc_count++;
            end
         end
      end
   end

   task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int waited);
      int n0;
      n0 = acc_count;
      waited = 0;
      op = o; in_r = a; in_rw = b; in_valid = 1'b1;
      while (1) begin
         @(posedge clk); #1;
         if (acc_count != n0) break;
         waited++;
         if (waited > 300) begin
            errors++;
            $display("FAIL accept_timeout: op %0d not accepted in %0d cycles", o, waited);
            break;
         end
      end
      in_valid = 1'b0;
      op = 4'($urandom); in_r = $urandom; in_rw = $urandom;
   endtask

   task automatic direct(input string name, input logic [3:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eo, input logic ec,
                         input logic ee, input int elat);
      int w, n;
      issue(o, a, b, w);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 100);
      chk({name, "_lat"}, n, elat);
      chk({name, "_out"}, out, eo);
      chk({name, "_z"}, is_zero, (eo == '0));
      chk({name, "_c"}, carry, ec);
      chk({name, "_e"}, err, ee);
      @(posedge clk); #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d results outstanding", q.size());
      end
   endtask

   function automatic logic [W-1:0] rand_opnd();
      case ($urandom_range(0, 5))
         0:       return W'($urandom_range(0, 40));
         1:       return '0;
         2:       return '1;
         3:       return W'($urandom_range(0, 300));
         default: return $urandom;
      endcase
   endfunction

   exp_t pin;

   initial begin
      int w;
      logic [3:0] o;
      int gap;

      // model pins
      pin = model(4'd0, 32'd2536, 32'd113);      chk("pin_add", pin.out, 2649);
      pin = model(4'd1, 32'd5, 32'd7);           chk("pin_sub_c", pin.c, 1);
      pin = model(4'd9, 32'd213, 32'd123);       chk("pin_op9", pin.out, 54651);
      pin = model(4'd10, 32'd2536, 32'd113);     chk("pin_mul", pin.out, 286568);
      pin = model(4'd8, 32'hF0F0, 32'h0FF0);     chk("pin_xor", pin.out, 32'hFF00);
      pin = model(4'd15, 32'd3, 32'd4);          chk("pin_ill", {pin.out, pin.z, pin.e}, {32'd0, 1'b1, 1'b1});

      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;

      direct("add",     4'd0, 32'd2536, 32'd113, 32'd2649, 1'b0, 1'b0, 1);
      direct("sub",     4'd1, 32'd2536, 32'd113, 32'd2423, 1'b0, 1'b0, 1);
      direct("op9",     4'd9, 32'd213,  32'd123, 32'd54651, 1'b0, 1'b0, 1);
      direct("add_ovf", 4'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1);
      direct("sub_brw", 4'd1, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b1, 1'b0, 1);
      direct("lsr32",   4'd2, 32'd1, 32'd32, 32'd0, 1'b0, 1'b0, 1);
      direct("rsr31",   4'd3, 32'h80000000, 32'd31, 32'd1, 1'b0, 1'b0, 1);
      direct("mul",     4'd10, 32'd2536, 32'd113, 32'd286568, 1'b0, 1'b0, 33);
`ifdef ALU_SEQ_DIV_EN
      direct("divu",    4'd11, 32'd2536, 32'd113, 32'd22, 1'b0, 1'b0, 33);
      direct("remu",    4'd12, 32'd2536, 32'd113, 32'd50, 1'b0, 1'b0, 33);
      direct("divu0",   4'd11, 32'd2536, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 1);
      direct("remu0",   4'd12, 32'd2536, 32'd0, 32'd2536, 1'b0, 1'b1, 1);
`else
      direct("divu_off", 4'd11, 32'd2536, 32'd113, 32'd0, 1'b0, 1'b1, 1);
      direct("remu_off", 4'd12, 32'd2536, 32'd113, 32'd0, 1'b0, 1'b1, 1);
`endif
      direct("ill14",   4'd14, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 1);

      // backpressure: result held while out_ready stays low
      ready_mode = 1;
      repeat (2) @(posedge clk);
      #1;
      issue(4'd6, 32'd2536, 32'd113, w);
      repeat (5) begin
         @(negedge clk);
         chk("bp_out", out, 96);
         chk("bp_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
      end
      @(posedge clk); #1;
      ready_mode = 0;
      @(posedge clk); #1;
      drain();

      // back-to-back single-cycle ops
      for (int i = 0; i < 6; i++) begin
         issue(4'd0, 32'(i * 1000), 32'(i), w);
         if (i > 0) chk("b2b_wait", w, 0);
      end
      drain();

      // reset in the middle of a multiply
      issue(4'd10, 32'd2536, 32'd113, w);
      repeat (9) @(posedge clk);
      #1 reset_n = 1'b0;
      @(posedge clk); #1 reset_n = 1'b1;
      @(negedge clk);
      chk("mrst_valid", out_valid, 0);
      chk("mrst_out", out, 0);
      chk("mrst_zero", is_zero, 1);
      chk("mrst_ready", in_ready, 1);
      @(posedge clk); #1;
      direct("post_rst_add", 4'd0, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1);

      // randomized traffic against the model
      ready_mode = 2;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) o = 4'($urandom_range(10, 12));
         else                            o = 4'($urandom_range(0, 15));
         issue(o, rand_opnd(), rand_opnd(), w);
         gap = $urandom_range(0, 2);
         repeat (gap) begin @(posedge clk); #1; end
      end
      ready_mode = 0;
      @(posedge clk); #1;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
